// File: rtl/even_parity_checker.sv
// Even-parity checker for a 3-bit word plus parity bit, with a registered
// per-word result and saturating error/check statistics.
module even_parity_checker #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             p,
    input  logic             valid_in,
    input  logic             clr,
    output logic             out,
    output logic             err_q,
    output logic             valid_q,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] chk_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             err_d;
    logic             valid_d;
    logic             sticky_d;
    logic [CNT_W-1:0] err_cnt_d;
    logic [CNT_W-1:0] chk_cnt_d;

    // Zero-latency parity error, independent of clock, reset and qualifiers.
    assign out = a ^ b ^ c ^ p;

    // Next-state: clr beats a same-cycle valid word for the statistics only.
    always_comb begin
        valid_d   = valid_in;
        err_d     = err_q;
        sticky_d  = err_sticky;
        err_cnt_d = err_cnt;
        chk_cnt_d = chk_cnt;

        if (valid_in) begin
            err_d = out;
        end

        if (clr) begin
            sticky_d  = 1'b0;
            err_cnt_d = '0;
            chk_cnt_d = '0;
        end else if (valid_in) begin
            if (chk_cnt != CNT_MAX) begin
                chk_cnt_d = chk_cnt + CNT_ONE;
            end
            if (out) begin
                sticky_d = 1'b1;
                if (err_cnt != CNT_MAX) begin
                    err_cnt_d = err_cnt + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
            chk_cnt    <= '0;
        end else begin
            err_q      <= err_d;
            valid_q    <= valid_d;
            err_sticky <= sticky_d;
            err_cnt    <= err_cnt_d;
            chk_cnt    <= chk_cnt_d;
        end
    end

endmodule

// File: tb/tb_even_parity_checker.sv
// Self-checking bench for even_parity_checker: directed scenarios plus random
// traffic compared against an integer-arithmetic reference model.
module tb_even_parity_checker;

    logic       clk;
    logic       rst;
    logic       a, b, c, p;
    logic       valid_in;
    logic       clr;
    logic       out_w,  out2_w;
    logic       err_q_w, err_q2_w;
    logic       valid_q_w, valid_q2_w;
    logic       sticky_w, sticky2_w;
    logic [7:0] err_cnt_w, chk_cnt_w;
    logic [1:0] err_cnt2_w, chk_cnt2_w;

    int tests;
    int failed;

    // Reference model state: plain integers, saturated with a min() rule.
    int m_err, m_valid, m_sticky;
    int m_ec, m_cc, m_ec2, m_cc2;

    even_parity_checker #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .p(p),
        .valid_in(valid_in), .clr(clr), .out(out_w), .err_q(err_q_w),
        .valid_q(valid_q_w), .err_sticky(sticky_w),
        .err_cnt(err_cnt_w), .chk_cnt(chk_cnt_w)
    );

    even_parity_checker #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .p(p),
        .valid_in(valid_in), .clr(clr), .out(out2_w), .err_q(err_q2_w),
        .valid_q(valid_q2_w), .err_sticky(sticky2_w),
        .err_cnt(err_cnt2_w), .chk_cnt(chk_cnt2_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int odd_ones(input logic [3:0] w);
        return $countones(w) % 2;
    endfunction

    function automatic int sat_inc(input int v, input int max_v);
        return (v + 1 > max_v) ? max_v : v + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one word, check the combinational output, clock, then check all state.
    task automatic cycle(input logic [3:0] w, input logic v, input logic cl, input logic r);
        int par;
        {a, b, c, p} = w;
        valid_in = v;
        clr      = cl;
        rst      = r;
        par      = odd_ones(w);
        #1;
        chk("out", {31'b0, out_w}, par);
        @(posedge clk);
        #1;
        if (r) begin
            m_err = 0; m_valid = 0; m_sticky = 0;
            m_ec = 0; m_cc = 0; m_ec2 = 0; m_cc2 = 0;
        end else begin
            m_valid = v;
            if (v) m_err = par;
            if (cl) begin
                m_sticky = 0; m_ec = 0; m_cc = 0; m_ec2 = 0; m_cc2 = 0;
            end else if (v) begin
                m_cc  = sat_inc(m_cc, 255);
                m_cc2 = sat_inc(m_cc2, 3);
                if (par == 1) begin
                    m_sticky = 1;
                    m_ec  = sat_inc(m_ec, 255);
                    m_ec2 = sat_inc(m_ec2, 3);
                end
            end
        end
        chk("err_q",      {31'b0, err_q_w},   m_err);
        chk("valid_q",    {31'b0, valid_q_w}, m_valid);
        chk("err_sticky", {31'b0, sticky_w},  m_sticky);
        chk("err_cnt",    {24'b0, err_cnt_w}, m_ec);
        chk("chk_cnt",    {24'b0, chk_cnt_w}, m_cc);
        chk("err_cnt_w2", {30'b0, err_cnt2_w}, m_ec2);
        chk("chk_cnt_w2", {30'b0, chk_cnt2_w}, m_cc2);
        chk("cnt_order",  {31'b0, (err_cnt_w <= chk_cnt_w)}, 32'd1);
    endtask

    initial begin
        logic [3:0] w;
        tests = 0;
        failed = 0;
        {a, b, c, p} = 4'b0000;
        valid_in = 1'b0;
        clr = 1'b0;
        rst = 1'b1;

        // Reset state
        cycle(4'b0000, 1'b0, 1'b0, 1'b1);
        cycle(4'b1011, 1'b1, 1'b1, 1'b1);
        chk("rst_cnt", {24'b0, chk_cnt_w}, 32'd0);

        // Exhaustive combinational check with spot constants
        for (int i = 0; i < 16; i++) cycle(4'(i), 1'b0, 1'b0, 1'b0);
        {a, b, c, p} = 4'b0111; #1; chk("out_0111", {31'b0, out_w}, 32'd1);
        {a, b, c, p} = 4'b1111; #1; chk("out_1111", {31'b0, out_w}, 32'd0);
        {a, b, c, p} = 4'b0011; #1; chk("out_0011", {31'b0, out_w}, 32'd0);
        a = 1'bx; #1; chk("out_xprop", {31'b0, out_w}, {31'b0, 1'bx});
        a = 1'b0; #1;

        // Single error word
        cycle(4'b1000, 1'b1, 1'b0, 1'b0);
        chk("t2_err_q", {31'b0, err_q_w}, 32'd1);
        chk("t2_sticky", {31'b0, sticky_w}, 32'd1);
        chk("t2_err_cnt", {24'b0, err_cnt_w}, 32'd1);
        chk("t2_chk_cnt", {24'b0, chk_cnt_w}, 32'd1);
        chk("t2_valid_q", {31'b0, valid_q_w}, 32'd1);

        // Ten good-parity words
        cycle(4'b0000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            w[3:1] = 3'($urandom_range(0, 7));
            w[0]   = ^w[3:1];
            cycle(w, 1'b1, 1'b0, 1'b0);
        end
        chk("t3_chk_cnt", {24'b0, chk_cnt_w}, 32'd10);
        chk("t3_err_cnt", {24'b0, err_cnt_w}, 32'd0);
        chk("t3_sticky", {31'b0, sticky_w}, 32'd0);

        // Saturation of the narrow instance
        cycle(4'b0000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(4'b0001, 1'b1, 1'b0, 1'b0);
        chk("t4_err_cnt2", {30'b0, err_cnt2_w}, 32'd3);
        chk("t4_chk_cnt2", {30'b0, chk_cnt2_w}, 32'd3);
        chk("t4_sticky2", {31'b0, sticky2_w}, 32'd1);
        chk("t4_err_cnt8", {24'b0, err_cnt_w}, 32'd5);

        // clr wins over a same-cycle valid error word
        cycle(4'b0001, 1'b1, 1'b1, 1'b0);
        chk("t5_err_cnt", {24'b0, err_cnt_w}, 32'd0);
        chk("t5_chk_cnt", {24'b0, chk_cnt_w}, 32'd0);
        chk("t5_sticky", {31'b0, sticky_w}, 32'd0);
        chk("t5_err_q", {31'b0, err_q_w}, 32'd1);
        chk("t5_valid_q", {31'b0, valid_q_w}, 32'd1);

        // err_q holds while valid_in is low
        cycle(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("hold_err_q", {31'b0, err_q_w}, 32'd1);

        // Randomized traffic with occasional clr / rst
        for (int i = 0; i < 400; i++) begin
            cycle(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 79) == 0));
        end

        // 8-bit saturation
        cycle(4'b0000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 260; i++) cycle(4'b0100, 1'b1, 1'b0, 1'b0);
        chk("sat_err_cnt8", {24'b0, err_cnt_w}, 32'd255);
        chk("sat_chk_cnt8", {24'b0, chk_cnt_w}, 32'd255);

        // Reset mid-stream with a valid word
        cycle(4'b1000, 1'b1, 1'b0, 1'b1);
        chk("t6_err_q", {31'b0, err_q_w}, 32'd0);
        chk("t6_valid_q", {31'b0, valid_q_w}, 32'd0);
        chk("t6_sticky", {31'b0, sticky_w}, 32'd0);
        chk("t6_err_cnt", {24'b0, err_cnt_w}, 32'd0);
        chk("t6_chk_cnt", {24'b0, chk_cnt_w}, 32'd0);
        chk("t6_out", {31'b0, out_w}, 32'd1);
        cycle(4'b0110, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
